inst_fetch_ctrl: RTL and testbench

- Sequences instruction fetch for the IF stage: owns the fetch PC and issues in-order requests to the instruction memory/icache.
- Tracks outstanding requests and discards stale responses after a branch redirect.
- Presents {pc, inst, valid} to the IF/ID pipeline register, and holds that output while downstream stalls.

---
 rtl/inst_fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues in-order icache requests,
// buffers responses in a small queue and drops stale responses after a redirect.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_req_valid_o,
  input  logic        icache_req_ready_i,
  output logic [31:0] icache_req_addr_o,
  input  logic        icache_rsp_valid_i,
  input  logic [31:0] icache_rsp_inst_i,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_inst_valid_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]    state_reg;
  logic [31:0]   pc_reg;
  logic [PW-1:0] head_reg, tail_reg, fill_reg;
  logic [CW-1:0] count_reg, unfilled_reg, discard_reg;

  logic [MAX_OUTSTANDING-1:0][31:0] q_pc;
  logic [MAX_OUTSTANDING-1:0][31:0] q_inst;
  logic [MAX_OUTSTANDING-1:0]       q_filled;

  logic          run;
  logic          head_valid;
  logic          alloc;
  logic          pop;
  logic          fill;
  logic          redirect;
  logic [CW-1:0] pending;

  assign run      = (state_reg == RUN);
  assign redirect = branch_flag_i && run;

  // Outputs are forced to zero while reset is held, not just after the edge.
  assign icache_req_valid_o = !rst && run && (count_reg < MAX_CNT) && !branch_flag_i;
  assign icache_req_addr_o  = rst ? 32'h0 : pc_reg;

  assign head_valid      = !rst && run && !branch_flag_i && (count_reg != '0) && q_filled[head_reg];
  assign if_inst_valid_o = head_valid;
  assign if_pc_o         = head_valid ? q_pc[head_reg]   : 32'h0;
  assign if_inst_o       = head_valid ? q_inst[head_reg] : 32'h0;

  assign alloc = icache_req_valid_o && icache_req_ready_i;
  assign pop   = head_valid && !stall_i;
  assign fill  = run && !branch_flag_i && icache_rsp_valid_i && (unfilled_reg != '0);

  // A response arriving in the redirect cycle is already accounted for and dropped.
  assign pending = unfilled_reg - CW'(icache_rsp_valid_i && (unfilled_reg != '0));

  genvar gi;
  generate
    for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_entry
      logic [31:0] e_pc_reg;
      logic [31:0] e_inst_reg;
      logic        e_filled_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          e_pc_reg     <= 32'h0;
          e_inst_reg   <= 32'h0;
          e_filled_reg <= 1'b0;
        end else if (redirect) begin
          e_filled_reg <= 1'b0;
        end else if (run) begin
          if (alloc && (tail_reg == PW'(gi))) begin
            e_pc_reg     <= pc_reg;
            e_filled_reg <= 1'b0;
          end
          if (fill && (fill_reg == PW'(gi))) begin
            e_inst_reg   <= icache_rsp_inst_i;
            e_filled_reg <= 1'b1;
          end
          if (pop && (head_reg == PW'(gi))) begin
            e_filled_reg <= 1'b0;
          end
        end
      end

      assign q_pc[gi]     = e_pc_reg;
      assign q_inst[gi]   = e_inst_reg;
      assign q_filled[gi] = e_filled_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (branch_flag_i) begin
      pc_reg <= branch_target_i;
    end else if (alloc) begin
      pc_reg <= pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RUN;
      head_reg     <= '0;
      tail_reg     <= '0;
      fill_reg     <= '0;
      count_reg    <= '0;
      unfilled_reg <= '0;
      discard_reg  <= '0;
    end else if (redirect) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      fill_reg     <= '0;
      count_reg    <= '0;
      unfilled_reg <= '0;
      if (pending != '0) begin
        discard_reg <= pending;
        state_reg   <= DRAIN;
      end
    end else if (!run) begin
      // Queue is empty while draining; only the stale-response counter moves.
      if (icache_rsp_valid_i && (discard_reg != '0)) begin
        discard_reg <= discard_reg - CW'(1);
        if (discard_reg == CW'(1)) begin
          state_reg <= RUN;
        end
      end
    end else begin
      if (alloc) tail_reg <= tail_reg + PW'(1);
      if (fill)  fill_reg <= fill_reg + PW'(1);
      if (pop)   head_reg <= head_reg + PW'(1);
      count_reg    <= count_reg + CW'(alloc) - CW'(pop);
      unfilled_reg <= unfilled_reg + CW'(alloc) - CW'(fill);
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: a queue-based reference model of the fetch buffer plus an
// in-order memory model that echoes the request address as the instruction.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int          MAX      = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        ready;
  logic [31:0] req_addr;
  logic        rsp_v;
  logic [31:0] rsp_d;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_valid;

  inst_fetch_ctrl #(.RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAX)) dut (
    .clk                (clk),
    .rst                (rst),
    .icache_req_valid_o (req_valid),
    .icache_req_ready_i (ready),
    .icache_req_addr_o  (req_addr),
    .icache_rsp_valid_i (rsp_v),
    .icache_rsp_inst_i  (rsp_d),
    .stall_i            (stall),
    .branch_flag_i      (br),
    .branch_target_i    (tgt),
    .if_pc_o            (out_pc),
    .if_inst_o          (out_inst),
    .if_inst_valid_o    (out_valid)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          filled;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_drain;
  int          m_discard;
  logic [31:0] mem_q[$];
  bit          rsp_en;
  int          errors;
  int          checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_rsp();
    if (rsp_en && mem_q.size() > 0) begin
      rsp_v = 1'b1;
      rsp_d = mem_q[0];
    end else begin
      rsp_v = 1'b0;
      rsp_d = 32'h0;
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mem_q.delete();
    m_pc      = RESET_PC;
    m_drain   = 1'b0;
    m_discard = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
    chk("rst_req_addr",  req_addr,          32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_pc",    out_pc,            32'h0);
    chk("rst_out_inst",  out_inst,          32'h0);
  endtask

  // One clock: compare at the falling edge, advance model and memory, drive next response.
  task automatic cycle();
    bit erv;
    bit hv;
    int unf;
    int pend;
    @(negedge clk);
    erv = !m_drain && (mq.size() < MAX) && !br;
    hv  = !m_drain && !br && (mq.size() > 0) && mq[0].filled;
    chk("req_valid", {31'b0, req_valid}, {31'b0, erv});
    if (erv) chk("req_addr", req_addr, m_pc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, hv});
    chk("out_pc",    out_pc,   hv ? mq[0].pc   : 32'h0);
    chk("out_inst",  out_inst, hv ? mq[0].inst : 32'h0);
    chk("inflight_le_max", {31'b0, mem_q.size() <= MAX}, 32'h1);

    unf = 0;
    foreach (mq[i]) if (!mq[i].filled) unf++;
    if (m_drain) begin
      if (rsp_v) begin
        m_discard--;
        if (m_discard == 0) m_drain = 1'b0;
      end
      if (br) m_pc = tgt;
    end else if (br) begin
      pend = unf - (rsp_v ? 1 : 0);
      mq.delete();
      if (pend > 0) begin
        m_drain   = 1'b1;
        m_discard = pend;
      end
      m_pc = tgt;
    end else begin
      if (rsp_v) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].filled) begin
            mq[i].filled = 1'b1;
            mq[i].inst   = rsp_d;
            break;
          end
        end
      end
      if (hv && !stall) void'(mq.pop_front());
      if (erv && ready) begin
        mq.push_back('{pc: m_pc, inst: 32'h0, filled: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end

    if (rsp_v) void'(mem_q.pop_front());
    if (req_valid && ready) mem_q.push_back(req_addr);
    @(posedge clk);
    #1;
    set_rsp();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    ready  = 1'b1;
    stall  = 1'b0;
    br     = 1'b0;
    tgt    = 32'h0;
    rsp_en = 1'b1;
    rsp_v  = 1'b0;
    rsp_d  = 32'h0;
    model_reset();

    #12;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_rsp();

    // Streaming with 1-cycle responses
    repeat (8) cycle();

    // Downstream stall for 5 cycles, then release
    stall = 1'b1;
    repeat (5) cycle();
    stall = 1'b0;
    repeat (4) cycle();

    // Branch with two unfilled entries and no response that cycle
    rsp_en = 1'b0;
    set_rsp();
    repeat (3) cycle();
    br  = 1'b1;
    tgt = 32'h1c000100;
    cycle();
    br     = 1'b0;
    rsp_en = 1'b1;
    set_rsp();
    repeat (8) cycle();

    // Branch in the same cycle as a response, one other pending
    rsp_en = 1'b0;
    set_rsp();
    repeat (3) cycle();
    rsp_en = 1'b1;
    set_rsp();
    br  = 1'b1;
    tgt = 32'h1c000200;
    cycle();
    br = 1'b0;
    repeat (6) cycle();

    // Branch while stalled with a valid output
    stall = 1'b1;
    repeat (4) cycle();
    br  = 1'b1;
    tgt = 32'h1c000300;
    cycle();
    br    = 1'b0;
    stall = 1'b0;
    repeat (5) cycle();

    // Memory not ready for 3 cycles
    ready = 1'b0;
    repeat (3) cycle();
    ready = 1'b1;
    repeat (4) cycle();

    // Random traffic
    repeat (300) begin
      ready  = ($urandom_range(0, 9) < 7);
      stall  = ($urandom_range(0, 9) < 3);
      rsp_en = ($urandom_range(0, 9) < 6);
      br     = !br && ($urandom_range(0, 19) == 0);
      tgt    = $urandom & 32'hffff_fffc;
      set_rsp();
      cycle();
    end
    br = 1'b0;

    // Reset asserted while draining stale responses
    ready  = 1'b1;
    stall  = 1'b0;
    rsp_en = 1'b0;
    set_rsp();
    repeat (3) cycle();
    br  = 1'b1;
    tgt = 32'h1c000400;
    cycle();
    br = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    model_reset();
    rsp_en = 1'b1;
    set_rsp();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_rsp();
    #1;
    chk("post_rst_req_valid", {31'b0, req_valid}, 32'h1);
    chk("post_rst_req_addr",  req_addr, RESET_PC);
    repeat (6) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
